// File: rtl/uart_pkg.sv
// Shared UART definitions: the state encoding, the data width and the CLKS_PER_BIT helper.
// The transmitter and the receiver both use this package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Number of system clocks per bit. The result uses integer division and must be at least 2.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. The count wraps through 0..CLKS_PER_BIT-1 and bit_tick marks the last cycle.
// The clear input restarts the period so that the first bit of a frame has full length.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_q + 1'b1;
        if (clear || (count_q == LAST)) begin
            count_next = '0;
        end
    end

    // NOTE: state flops take non-blocking assignments only; the next value comes from always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign bit_tick = (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a valid/ready byte input. The default frame is 8N1.
// Define UART_TX_PARITY_EN to add an even-parity bit, which gives an 8E1 frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_next;
    logic [UART_DATA_BITS-1:0] shift_q, shift_next;
    logic [2:0]                bit_cnt_q, bit_cnt_next;
    logic                      tx_q, tx_next;
    logic                      busy_q;
    logic                      accept;
    logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_next;
`endif

    assign tx_ready = (state_q == IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .bit_tick(bit_tick)
    );

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        state_next   = state_q;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_q;
`endif
        tx_next      = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next   = shift_q >> 1;
                    bit_cnt_next = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is decoded from the next state. As a result, the tx flop holds the
        // correct level in the same cycle that the state changes.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_next;
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_next;
            tx_q      <= tx_next;
            busy_q    <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
